mac_rx_pwr_seq: RTL and testbench

// Power-state sequencer for the MAC receive path. Accepts a sleep request from the

---
 rtl/mac_rx_pwr_seq_if.sv | 31 +++
 rtl/mac_rx_pwr_seq.sv | 216 +++++++++++++++++++++
 tb/tb_mac_rx_pwr_seq.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_rx_pwr_seq_if.sv
// rtl/mac_rx_pwr_seq_if.sv - handshake bundle between power monitor/PHY side and the rx power sequencer
interface mac_rx_pwr_seq_if;
    // requests and line activity into the sequencer
    logic       sleep_req;
    logic       crs;
    logic       rx_dv;
    logic       rx_er;
    logic [2:0] wake_en;
    logic       pwr_ack;
    // controls and status out of the sequencer
    logic       rx_gate_en;
    logic       rx_isolate;
    logic       rx_save;
    logic       rx_restore;
    logic       rx_pwr_on;
    logic       sleep_ack;
    logic       wake_evt;
    logic       seq_err;

    modport master (
        output sleep_req, crs, rx_dv, rx_er, wake_en, pwr_ack,
        input  rx_gate_en, rx_isolate, rx_save, rx_restore, rx_pwr_on,
               sleep_ack, wake_evt, seq_err
    );

    modport slave (
        input  sleep_req, crs, rx_dv, rx_er, wake_en, pwr_ack,
        output rx_gate_en, rx_isolate, rx_save, rx_restore, rx_pwr_on,
               sleep_ack, wake_evt, seq_err
    );
endinterface

// File: rtl/mac_rx_pwr_seq.sv
// rtl/mac_rx_pwr_seq.sv - rx path power sequencer: isolate, save, gate, power off and reverse
module mac_rx_pwr_seq #(
    parameter int CNT_W   = 8,
    parameter int ISO_DLY = 4,
    parameter int RET_DLY = 4,
    parameter int PWR_DLY = 16
) (
    input logic               rx_clk,
    input logic               n_hreset,
    mac_rx_pwr_seq_if.slave   io_rx
);

    typedef enum logic [3:0] {
        ST_RUN,
        ST_ISO,
        ST_SAVE,
        ST_GATE,
        ST_PWR_DN,
        ST_OFF,
        ST_PWR_UP,
        ST_PWR_SET,
        ST_RESTORE,
        ST_UNGATE
    } state_t;

    localparam logic [CNT_W-1:0] C_ISO = CNT_W'(ISO_DLY);
    localparam logic [CNT_W-1:0] C_RET = CNT_W'(RET_DLY);
    localparam logic [CNT_W-1:0] C_PWR = CNT_W'(PWR_DLY);
    localparam logic [CNT_W-1:0] C_TMO = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_wake_pend;
    logic             r_req_s1, r_req_s2;
    logic             r_ack_s1, r_ack_s2;
    logic             r_gate_en, r_isolate, r_save, r_restore;
    logic             r_pwr_on, r_sleep_ack, r_wake_evt, r_seq_err;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_wake_pend_nxt;
    logic             w_wake_evt_nxt;
    logic             w_seq_err_nxt;
    logic             w_act;
    logic             w_cnt_one;
    logic             w_cnt_dec;

    // Raw line activity, masked per source; PHY signals are already in rx_clk domain.
    assign w_act     = |(io_rx.wake_en & {io_rx.rx_er, io_rx.rx_dv, io_rx.crs});
    assign w_cnt_one = (r_cnt == C_ONE);
    assign w_cnt_dec = 1'b0;

    // Two-flop synchronizers; pwr_ack resets high because the rx domain powers up on.
    always_ff @(posedge rx_clk or negedge n_hreset) begin
        if (!n_hreset) begin
            r_req_s1 <= 1'b0;
            r_req_s2 <= 1'b0;
            r_ack_s1 <= 1'b1;
            r_ack_s2 <= 1'b1;
        end else begin
            r_req_s1 <= io_rx.sleep_req;
            r_req_s2 <= r_req_s1;
            r_ack_s1 <= io_rx.pwr_ack;
            r_ack_s2 <= r_ack_s1;
        end
    end

    // Next-state logic; the counter is loaded on entry and the state exits when it reads 1.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_wake_pend_nxt = r_wake_pend;
        w_wake_evt_nxt  = w_cnt_dec;
        w_seq_err_nxt   = r_seq_err;
        case (r_state)
            ST_RUN: begin
                if (r_req_s2 && !w_act) begin
                    w_state_nxt = ST_ISO;
                    w_cnt_nxt   = C_ISO;
                end
            end
            ST_ISO: begin
                if (w_act) begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = '0;
                end else if (w_cnt_one) begin
                    w_state_nxt = ST_SAVE;
                    w_cnt_nxt   = C_RET;
                end else begin
                    w_cnt_nxt   = r_cnt - C_ONE;
                end
            end
            ST_SAVE: begin
                if (w_act) w_wake_pend_nxt = 1'b1;
                if (w_cnt_one) begin
                    w_state_nxt = ST_GATE;
                    w_cnt_nxt   = C_ONE;
                end else begin
                    w_cnt_nxt   = r_cnt - C_ONE;
                end
            end
            ST_GATE: begin
                if (w_act) w_wake_pend_nxt = 1'b1;
                w_state_nxt = ST_PWR_DN;
                w_cnt_nxt   = C_TMO;
            end
            ST_PWR_DN: begin
                if (w_act) w_wake_pend_nxt = 1'b1;
                if (!r_ack_s2) begin
                    w_state_nxt = ST_OFF;
                    w_cnt_nxt   = '0;
                end else if (w_cnt_one) begin
                    w_seq_err_nxt = 1'b1;
                    w_state_nxt   = ST_OFF;
                    w_cnt_nxt     = '0;
                end else begin
                    w_cnt_nxt   = r_cnt - C_ONE;
                end
            end
            ST_OFF: begin
                // Activity wins over a dropped request so the wake is reported.
                if (w_act || r_wake_pend) begin
                    w_state_nxt     = ST_PWR_UP;
                    w_cnt_nxt       = C_TMO;
                    w_wake_evt_nxt  = 1'b1;
                    w_wake_pend_nxt = 1'b0;
                end else if (!r_req_s2) begin
                    w_state_nxt     = ST_PWR_UP;
                    w_cnt_nxt       = C_TMO;
                    w_wake_pend_nxt = 1'b0;
                end
            end
            ST_PWR_UP: begin
                if (r_ack_s2) begin
                    w_state_nxt = ST_PWR_SET;
                    w_cnt_nxt   = C_PWR;
                end else if (w_cnt_one) begin
                    w_seq_err_nxt = 1'b1;
                    w_state_nxt   = ST_PWR_SET;
                    w_cnt_nxt     = C_PWR;
                end else begin
                    w_cnt_nxt   = r_cnt - C_ONE;
                end
            end
            ST_PWR_SET: begin
                if (w_cnt_one) begin
                    w_state_nxt = ST_RESTORE;
                    w_cnt_nxt   = C_RET;
                end else begin
                    w_cnt_nxt   = r_cnt - C_ONE;
                end
            end
            ST_RESTORE: begin
                if (w_cnt_one) begin
                    w_state_nxt = ST_UNGATE;
                    w_cnt_nxt   = C_ISO;
                end else begin
                    w_cnt_nxt   = r_cnt - C_ONE;
                end
            end
            ST_UNGATE: begin
                if (w_cnt_one) begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt - C_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // State, counter and registered outputs decoded from the next state.
    always_ff @(posedge rx_clk or negedge n_hreset) begin
        if (!n_hreset) begin
            r_state     <= ST_RUN;
            r_cnt       <= '0;
            r_wake_pend <= 1'b0;
            r_gate_en   <= 1'b1;
            r_isolate   <= 1'b0;
            r_save      <= 1'b0;
            r_restore   <= 1'b0;
            r_pwr_on    <= 1'b1;
            r_sleep_ack <= 1'b0;
            r_wake_evt  <= 1'b0;
            r_seq_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_wake_pend <= w_wake_pend_nxt;
            r_gate_en   <= !(w_state_nxt inside {ST_GATE, ST_PWR_DN, ST_OFF, ST_PWR_UP,
                                                 ST_PWR_SET, ST_RESTORE});
            r_isolate   <= (w_state_nxt != ST_RUN);
            r_save      <= (w_state_nxt == ST_SAVE);
            r_restore   <= (w_state_nxt == ST_RESTORE);
            r_pwr_on    <= !(w_state_nxt inside {ST_PWR_DN, ST_OFF});
            r_sleep_ack <= (w_state_nxt == ST_OFF);
            r_wake_evt  <= w_wake_evt_nxt;
            r_seq_err   <= w_seq_err_nxt;
        end
    end

    assign io_rx.rx_gate_en = r_gate_en;
    assign io_rx.rx_isolate = r_isolate;
    assign io_rx.rx_save    = r_save;
    assign io_rx.rx_restore = r_restore;
    assign io_rx.rx_pwr_on  = r_pwr_on;
    assign io_rx.sleep_ack  = r_sleep_ack;
    assign io_rx.wake_evt   = r_wake_evt;
    assign io_rx.seq_err    = r_seq_err;

endmodule

// File: tb/tb_mac_rx_pwr_seq.sv
// tb/tb_mac_rx_pwr_seq.sv - self-checking bench for mac_rx_pwr_seq with pulse scoreboard
module tb_mac_rx_pwr_seq;

    localparam int S_GATE = 0, S_ISO = 1, S_SAVE = 2, S_REST = 3;
    localparam int S_PWR = 4, S_ACK = 5, S_EVT = 6, S_ERR = 7;

    logic       rx_clk   = 1'b0;
    logic       n_hreset = 1'b1;
    logic [2:0] ack_d    = 3'b111;
    logic       ack_stuck = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    int cyc;
    int run_len[4];
    int q_save[$];
    int q_rest[$];
    int q_ack[$];
    int q_evt[$];

    always #5 rx_clk = ~rx_clk;

    mac_rx_pwr_seq_if u_if();

    mac_rx_pwr_seq dut (
        .rx_clk   (rx_clk),
        .n_hreset (n_hreset),
        .io_rx    (u_if)
    );

    // power switch model: pwr_ack follows rx_pwr_on three cycles later, optionally stuck on
    always @(posedge rx_clk) ack_d <= {ack_d[1:0], u_if.rx_pwr_on};
    assign u_if.pwr_ack = ack_stuck | ack_d[2];

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic sig(input int s);
        case (s)
            S_GATE:  return u_if.rx_gate_en;
            S_ISO:   return u_if.rx_isolate;
            S_SAVE:  return u_if.rx_save;
            S_REST:  return u_if.rx_restore;
            S_PWR:   return u_if.rx_pwr_on;
            S_ACK:   return u_if.sleep_ack;
            S_EVT:   return u_if.wake_evt;
            default: return u_if.seq_err;
        endcase
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge rx_clk);
        #1;
    endtask

    task automatic wait_for(input int s, input logic v, input int budget, input string tag,
                            output int cycles);
        cycles = 0;
        for (int i = 1; i <= budget; i++) begin
            tick(1);
            if (sig(s) == v) begin
                cycles = i;
                return;
            end
        end
        chk({tag, "_timeout"}, budget + 1, budget);
    endtask

    task automatic chk_reset(input string tag);
        chk(tag, int'({u_if.rx_gate_en, u_if.rx_isolate, u_if.rx_save, u_if.rx_restore,
                       u_if.rx_pwr_on, u_if.sleep_ack, u_if.wake_evt, u_if.seq_err}),
            int'(8'b1000_1000));
    endtask

    // scoreboard: a finished pulse pops the expected length for its kind (-1 = any length)
    task automatic pulse_end(input int k, input int len);
        int    e;
        logic  have;
        string nm;
        e = -1;
        have = 1'b0;
        case (k)
            0: begin nm = "save";    have = (q_save.size() > 0); if (have) e = q_save.pop_front(); end
            1: begin nm = "restore"; have = (q_rest.size() > 0); if (have) e = q_rest.pop_front(); end
            2: begin nm = "sleep_ack"; have = (q_ack.size() > 0); if (have) e = q_ack.pop_front(); end
            default: begin nm = "wake_evt"; have = (q_evt.size() > 0); if (have) e = q_evt.pop_front(); end
        endcase
        if (!have) chk({nm, "_unexpected_pulse"}, 1, 0);
        else if (e >= 0) chk({nm, "_len"}, len, e);
    endtask

    task automatic track(input int k, input logic v);
        if (v) run_len[k]++;
        else if (run_len[k] > 0) begin
            pulse_end(k, run_len[k]);
            run_len[k] = 0;
        end
    endtask

    // monitor on the falling edge, away from the sampling edge of the DUT
    always @(negedge rx_clk) begin
        chk("save_restore_excl", int'(u_if.rx_save & u_if.rx_restore), 0);
        track(0, u_if.rx_save);
        track(1, u_if.rx_restore);
        track(2, u_if.sleep_ack);
        track(3, u_if.wake_evt);
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        u_if.sleep_req = 1'b0;
        u_if.crs       = 1'b0;
        u_if.rx_dv     = 1'b0;
        u_if.rx_er     = 1'b0;
        u_if.wake_en   = 3'b000;
        for (int k = 0; k < 4; k++) run_len[k] = 0;
        #1 n_hreset = 1'b0;
        #1 chk_reset("reset_values");
        tick(2);
        n_hreset = 1'b1;
        tick(2);
        chk_reset("post_reset_idle");

        // 1: idle line, sleep request walks down to OFF
        q_save.push_back(4);
        u_if.wake_en   = 3'b111;
        u_if.sleep_req = 1'b1;
        tick(2);
        chk("s1_iso_pre", int'(u_if.rx_isolate), 0);
        tick(1);
        chk("s1_iso_rise", int'(u_if.rx_isolate), 1);
        wait_for(S_SAVE, 1'b1, 20, "s1_save", cyc);
        chk("s1_iso_hold", cyc, 4);
        wait_for(S_GATE, 1'b0, 20, "s1_gate", cyc);
        chk("s1_save_to_gate", cyc, 4);
        wait_for(S_PWR, 1'b0, 20, "s1_pdn", cyc);
        chk("s1_gate_to_pdn", cyc, 1);
        wait_for(S_ACK, 1'b1, 40, "s1_off", cyc);
        chk("s1_pdn_to_off", cyc, 6);
        tick(3);
        chk("s1_off_hold", int'({u_if.sleep_ack, u_if.rx_gate_en, u_if.rx_pwr_on,
                                u_if.rx_isolate, u_if.seq_err}), int'(5'b10010));

        // 2: rx_dv wake from OFF, full power-up timing
        q_evt.push_back(1);
        q_ack.push_back(-1);
        q_rest.push_back(4);
        u_if.wake_en = 3'b010;
        u_if.rx_dv   = 1'b1;
        tick(1);
        chk("s2_wake", int'({u_if.wake_evt, u_if.sleep_ack, u_if.rx_pwr_on}), int'(3'b101));
        u_if.rx_dv     = 1'b0;
        u_if.sleep_req = 1'b0;
        wait_for(S_REST, 1'b1, 60, "s2_restore", cyc);
        chk("s2_up_to_restore", cyc, 22);
        wait_for(S_GATE, 1'b1, 20, "s2_ungate", cyc);
        chk("s2_restore_to_ungate", cyc, 4);
        wait_for(S_ISO, 1'b0, 20, "s2_run", cyc);
        chk("s2_ungate_to_run", cyc, 4);
        chk("s2_run_outs", int'({u_if.rx_pwr_on, u_if.seq_err}), int'(2'b10));

        // 3: crs during ISO aborts before any save
        tick(3);
        u_if.wake_en   = 3'b001;
        u_if.sleep_req = 1'b1;
        tick(3);
        chk("s3_iso", int'(u_if.rx_isolate), 1);
        tick(1);
        u_if.crs       = 1'b1;
        u_if.sleep_req = 1'b0;
        tick(1);
        chk("s3_abort", int'(u_if.rx_isolate), 0);
        tick(3);
        u_if.crs = 1'b0;
        tick(10);
        chk("s3_stay_run", int'({u_if.rx_isolate, u_if.rx_gate_en}), int'(2'b01));

        // 4: rx_er during SAVE -> pending wake, OFF for exactly one cycle
        q_save.push_back(4);
        q_ack.push_back(1);
        q_evt.push_back(1);
        q_rest.push_back(4);
        u_if.wake_en   = 3'b111;
        u_if.sleep_req = 1'b1;
        wait_for(S_SAVE, 1'b1, 20, "s4_save", cyc);
        u_if.rx_er = 1'b1;
        tick(1);
        u_if.rx_er = 1'b0;
        wait_for(S_ACK, 1'b1, 40, "s4_off", cyc);
        chk("s4_off_pwr", int'(u_if.rx_pwr_on), 0);
        tick(1);
        chk("s4_leave_off", int'({u_if.sleep_ack, u_if.wake_evt, u_if.rx_pwr_on}), int'(3'b011));
        u_if.sleep_req = 1'b0;
        wait_for(S_ISO, 1'b0, 100, "s4_run", cyc);
        chk("s4_run_gate", int'(u_if.rx_gate_en), 1);

        // 5: pwr_ack stuck high -> timeout, sticky seq_err
        q_save.push_back(4);
        q_ack.push_back(-1);
        q_rest.push_back(4);
        tick(2);
        u_if.wake_en   = 3'b000;
        ack_stuck      = 1'b1;
        u_if.sleep_req = 1'b1;
        wait_for(S_PWR, 1'b0, 30, "s5_pdn", cyc);
        chk("s5_err_pre", int'(u_if.seq_err), 0);
        wait_for(S_ACK, 1'b1, 400, "s5_off", cyc);
        chk("s5_timeout_len", cyc, 255);
        chk("s5_err_set", int'(u_if.seq_err), 1);
        ack_stuck = 1'b0;
        tick(3);
        u_if.sleep_req = 1'b0;
        wait_for(S_ISO, 1'b0, 100, "s5_run", cyc);
        chk("s5_err_sticky", int'(u_if.seq_err), 1);

        // 6a: wake_en=0 blocks rx_dv wake, then reset in OFF
        q_save.push_back(4);
        q_ack.push_back(-1);
        tick(2);
        u_if.sleep_req = 1'b1;
        wait_for(S_ACK, 1'b1, 60, "s6_off", cyc);
        u_if.rx_dv = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            chk("s6_no_wake", int'({u_if.sleep_ack, u_if.wake_evt}), int'(2'b10));
        end
        #2;
        n_hreset       = 1'b0;
        u_if.sleep_req = 1'b0;
        u_if.rx_dv     = 1'b0;
        #1 chk_reset("s6_reset_off");
        #1 n_hreset = 1'b1;
        tick(5);
        chk("s6_run_after_reset", int'(u_if.rx_isolate), 0);

        // 6b: reset mid-RESTORE
        q_save.push_back(4);
        q_ack.push_back(-1);
        q_rest.push_back(-1);
        u_if.sleep_req = 1'b1;
        wait_for(S_ACK, 1'b1, 60, "s6b_off", cyc);
        u_if.sleep_req = 1'b0;
        wait_for(S_REST, 1'b1, 100, "s6b_restore", cyc);
        tick(1);
        #2;
        n_hreset = 1'b0;
        #1 chk_reset("s6_reset_restore");
        #1 n_hreset = 1'b1;
        tick(8);
        chk("s6b_run", int'({u_if.rx_isolate, u_if.rx_gate_en, u_if.rx_pwr_on}), int'(3'b011));

        chk("q_save_left", q_save.size(), 0);
        chk("q_restore_left", q_rest.size(), 0);
        chk("q_ack_left", q_ack.size(), 0);
        chk("q_evt_left", q_evt.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
